// File: rtl/nw_pkg.sv
`default_nettype none
// =============================================================================
// Package : nw_pkg
// Shared Needleman-Wunsch types: default score width/gap, FSM encoding, saturating add.
// Revision: 1.0
// =============================================================================
package nw_pkg;

    localparam int c_SW_DEFAULT  = 9;
    localparam int c_GAP_DEFAULT = -2;

    typedef logic [2:0] state_t;

    localparam state_t c_ST_IDLE    = 3'd0;
    localparam state_t c_ST_INIT    = 3'd1;
    localparam state_t c_ST_FETCH   = 3'd2;
    localparam state_t c_ST_PRESENT = 3'd3;
    localparam state_t c_ST_DONE    = 3'd4;

    // a + b clamped to the range of a w-bit signed number
    function automatic int sat_add(input int a, input int b, input int w);
        longint sum;
        longint lo;
        longint hi;
        sum = longint'(a) + longint'(b);
        lo  = -(longint'(1) <<< (w - 1));
        hi  = (longint'(1) <<< (w - 1)) - 1;
        if (sum < lo) return int'(lo);
        if (sum > hi) return int'(hi);
        return int'(sum);
    endfunction

endpackage
`default_nettype wire

// File: rtl/score_stream_manager_if.sv
`default_nettype none
// =============================================================================
// Interface : score_stream_manager_if
// Control, neighbour handshake and cell-stream signals of the score stream manager.
// Revision: 1.0
// =============================================================================
interface score_stream_manager_if #(
    parameter int SW      = 9,
    parameter int BitAddr = 8
);
    logic                 start;
    logic [BitAddr:0]     len_a;
    logic [BitAddr:0]     len_b;
    logic                 max_valid;
    logic signed [SW-1:0] max;
    logic                 busy;
    logic                 err;
    logic                 nb_valid;
    logic signed [SW-1:0] diag;
    logic signed [SW-1:0] left;
    logic signed [SW-1:0] up;
    logic [BitAddr:0]     cell_i;
    logic [BitAddr:0]     cell_j;
    logic                 wr_valid;
    logic signed [SW-1:0] wr_score;
    logic                 done;
    logic signed [SW-1:0] final_score;

    modport slave (
        input  start, len_a, len_b, max_valid, max,
        output busy, err, nb_valid, diag, left, up, cell_i, cell_j,
               wr_valid, wr_score, done, final_score
    );

    modport master (
        output start, len_a, len_b, max_valid, max,
        input  busy, err, nb_valid, diag, left, up, cell_i, cell_j,
               wr_valid, wr_score, done, final_score
    );
endinterface
`default_nettype wire

// File: rtl/score_row_buffer.sv
`default_nettype none
// =============================================================================
// Module  : score_row_buffer
// (N+1) x SW single-port synchronous RAM with a registered one-cycle read.
// Revision: 1.0
// =============================================================================
module score_row_buffer #(
    parameter int N  = 128,
    parameter int SW = 9,
    parameter int AW = $clog2(N + 1)
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic                 i_we,
    input  wire logic                 i_re,
    input  wire logic [AW-1:0]        i_addr,
    input  wire logic signed [SW-1:0] i_wdata,
    output logic signed [SW-1:0]      o_rdata
);
    logic signed [SW-1:0] r_mem [0:N];
    logic signed [SW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Only the read register is reset; array contents are rebuilt before use.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/score_stream_manager.sv
`default_nettype none
// =============================================================================
// Module  : score_stream_manager
// Linear-space NW score manager: one score row, neighbour handshake, cell stream.
// Revision: 1.0
// =============================================================================
module score_stream_manager
    import nw_pkg::*;
#(
    parameter int N       = 128,
    parameter int SW      = c_SW_DEFAULT,
    parameter int GAP     = c_GAP_DEFAULT,
    parameter int BitAddr = $clog2(N + 1)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    score_stream_manager_if.slave bus
);
    localparam logic [BitAddr:0]     c_N       = N[BitAddr:0];
    localparam logic [BitAddr:0]     c_ONE     = {{BitAddr{1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] c_GAP_SAT = SW'(sat_add(0, GAP, SW));

    state_t               r_state;
    state_t               w_state_next;
    logic [BitAddr:0]     r_len_a;
    logic [BitAddr:0]     r_len_b;
    logic [BitAddr:0]     r_i;
    logic [BitAddr:0]     r_j;
    logic [BitAddr:0]     r_idx;
    logic signed [SW-1:0] r_acc;
    logic signed [SW-1:0] r_col;
    logic signed [SW-1:0] r_diag;
    logic signed [SW-1:0] r_left;
    logic signed [SW-1:0] r_final;
    logic                 r_err;

    logic                 w_start_ok;
    logic                 w_accept;
    logic                 w_last_col;
    logic                 w_last_row;
    logic signed [SW-1:0] w_acc_next;
    logic signed [SW-1:0] w_col_next;

    logic                 w_we;
    logic                 w_re;
    logic [BitAddr-1:0]   w_addr;
    logic signed [SW-1:0] w_wdata;
    logic signed [SW-1:0] w_rdata;

    assign w_start_ok = (bus.len_a != '0) && (bus.len_a <= c_N) &&
                        (bus.len_b != '0) && (bus.len_b <= c_N);
    assign w_accept   = (r_state == c_ST_PRESENT) && bus.max_valid;
    assign w_last_col = (r_j == r_len_b);
    assign w_last_row = (r_i == r_len_a);
    assign w_acc_next = SW'(sat_add(int'(r_acc), GAP, SW));
    assign w_col_next = SW'(sat_add(int'(r_col), GAP, SW));

    score_row_buffer #(
        .N  (N),
        .SW (SW),
        .AW (BitAddr)
    ) u_row (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_addr  (w_addr),
        .i_wdata (w_wdata),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE:    if (bus.start && w_start_ok) w_state_next = c_ST_INIT;
            c_ST_INIT:    if (r_idx == r_len_b) w_state_next = c_ST_FETCH;
            c_ST_FETCH:   w_state_next = c_ST_PRESENT;
            c_ST_PRESENT: begin
                if (bus.max_valid) begin
                    w_state_next = (w_last_col && w_last_row) ? c_ST_DONE : c_ST_FETCH;
                end
            end
            c_ST_DONE:    w_state_next = c_ST_IDLE;
            default:      w_state_next = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len_a <= '0;
            r_len_b <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_idx   <= '0;
            r_acc   <= '0;
            r_col   <= '0;
            r_diag  <= '0;
            r_left  <= '0;
            r_final <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        if (w_start_ok) begin
                            r_len_a <= bus.len_a;
                            r_len_b <= bus.len_b;
                            r_idx   <= '0;
                            r_acc   <= '0;
                            r_i     <= '0;
                            r_j     <= '0;
                            r_diag  <= '0;
                            r_left  <= '0;
                            r_final <= '0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                c_ST_INIT: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx + c_ONE;
                    if (r_idx == r_len_b) begin
                        r_i    <= c_ONE;
                        r_j    <= c_ONE;
                        r_diag <= '0;
                        r_left <= c_GAP_SAT;
                        r_col  <= c_GAP_SAT;
                    end
                end
                c_ST_PRESENT: begin
                    if (bus.max_valid) begin
                        if (!w_last_col) begin
                            r_diag <= w_rdata;
                            r_left <= bus.max;
                            r_j    <= r_j + c_ONE;
                        end else if (!w_last_row) begin
                            // Wrap to column 1: neighbours come from the column-0 accumulator.
                            r_i    <= r_i + c_ONE;
                            r_j    <= c_ONE;
                            r_col  <= w_col_next;
                            r_diag <= r_col;
                            r_left <= w_col_next;
                        end else begin
                            r_final <= bus.max;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy        = (r_state == c_ST_INIT) || (r_state == c_ST_FETCH) ||
                          (r_state == c_ST_PRESENT);
        bus.nb_valid    = (r_state == c_ST_PRESENT);
        bus.done        = (r_state == c_ST_DONE);
        bus.err         = r_err;
        bus.diag        = r_diag;
        bus.left        = r_left;
        bus.up          = w_rdata;
        bus.cell_i      = r_i;
        bus.cell_j      = r_j;
        bus.wr_valid    = w_accept;
        bus.wr_score    = w_accept ? bus.max : '0;
        bus.final_score = r_final;
        w_re            = (r_state == c_ST_FETCH);
        w_we            = (r_state == c_ST_INIT) || w_accept;
        w_addr          = (r_state == c_ST_INIT) ? r_idx[BitAddr-1:0] : r_j[BitAddr-1:0];
        w_wdata         = (r_state == c_ST_INIT) ? r_acc : bus.max;
    end
endmodule
`default_nettype wire

// File: tb/tb_score_stream_manager.sv
`default_nettype none
// =============================================================================
// Module  : tb_score_stream_manager
// Self-checking bench: vector table, neighbour checks and a write-stream scoreboard.
// Revision: 1.0
// =============================================================================
module tb_score_stream_manager;
    localparam int c_N     = 8;
    localparam int c_AW    = $clog2(c_N + 1);
    localparam int c_SW    = 9;
    localparam int c_GAP   = -2;
    localparam int c_SW_S  = 4;
    localparam int c_GAP_S = -3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    score_stream_manager_if #(.SW(c_SW),   .BitAddr(c_AW)) bus_a ();
    score_stream_manager_if #(.SW(c_SW_S), .BitAddr(c_AW)) bus_s ();

    score_stream_manager #(.N(c_N), .SW(c_SW), .GAP(c_GAP), .BitAddr(c_AW)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    score_stream_manager #(.N(c_N), .SW(c_SW_S), .GAP(c_GAP_S), .BitAddr(c_AW)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    typedef struct {
        int i;
        int j;
        int s;
    } wr_t;

    typedef struct {
        int i;
        int j;
        int diag;
        int left;
        int up;
        int reply;
        int bp;
        bit stray;
    } vec_t;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  n_wr     = 0;
    int  n_done   = 0;
    wr_t sb_q[$];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (bus_a.wr_valid) begin
            n_wr++;
            if (sb_q.size() == 0) begin
                check("wr_unexpected", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("wr_i", int'(bus_a.cell_i), e.i);
                check("wr_j", int'(bus_a.cell_j), e.j);
                check("wr_score", int'(bus_a.wr_score), e.s);
            end
        end
        if (bus_a.done) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"},     int'(bus_a.busy), 0);
        check({tag, "_nb_valid"}, int'(bus_a.nb_valid), 0);
        check({tag, "_done"},     int'(bus_a.done), 0);
        check({tag, "_err"},      int'(bus_a.err), 0);
        check({tag, "_wr_valid"}, int'(bus_a.wr_valid), 0);
        check({tag, "_diag"},     int'(bus_a.diag), 0);
        check({tag, "_left"},     int'(bus_a.left), 0);
        check({tag, "_up"},       int'(bus_a.up), 0);
        check({tag, "_cell_i"},   int'(bus_a.cell_i), 0);
        check({tag, "_cell_j"},   int'(bus_a.cell_j), 0);
        check({tag, "_wr_score"}, int'(bus_a.wr_score), 0);
        check({tag, "_final"},    int'(bus_a.final_score), 0);
    endtask

    task automatic do_start(input int la, input int lb, output int lat);
        bus_a.len_a = (c_AW + 1)'(la);
        bus_a.len_b = (c_AW + 1)'(lb);
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        lat = 1;
        while (!bus_a.nb_valid && lat < 300) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_cell(input int ei, input int ej, input int ed, input int el,
                            input int eu, input int rep, input int bp, input bit stray);
        int n = 0;
        int st;
        while (!bus_a.nb_valid && n < 100) begin
            tick();
            n++;
        end
        check("nb_valid", int'(bus_a.nb_valid), 1);
        check("cell_i", int'(bus_a.cell_i), ei);
        check("cell_j", int'(bus_a.cell_j), ej);
        check("diag", int'(bus_a.diag), ed);
        check("left", int'(bus_a.left), el);
        check("up", int'(bus_a.up), eu);
        for (int k = 0; k < bp; k++) begin
            tick();
            st = (bus_a.nb_valid && int'(bus_a.diag) == ed && int'(bus_a.left) == el &&
                  int'(bus_a.up) == eu && int'(bus_a.cell_j) == ej) ? 1 : 0;
            check("bp_stable", st, 1);
        end
        bus_a.max_valid = 1'b1;
        bus_a.max       = c_SW'(rep);
        sb_q.push_back('{ei, ej, rep});
        tick();
        if (stray) begin
            // Held through FETCH with a bogus value; must not produce a write.
            bus_a.max = c_SW'(77);
            tick();
        end
        bus_a.max_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[4];
        int   lat;
        int   wr0;
        int   h[0:8][0:8];
        int   sa[1:8];
        int   sb[1:8];
        int   exp_up[1:5];
        int   n;
        int   ed, el, eu, rep, s;

        tbl[0] = '{1, 1,  0, -2, -2,  1, 0, 1'b1};
        tbl[1] = '{1, 2, -2,  1, -4, -1, 5, 1'b0};
        tbl[2] = '{2, 1, -2, -4,  1,  3, 0, 1'b0};
        tbl[3] = '{2, 2,  1,  3, -1,  2, 0, 1'b0};
        exp_up = '{-3, -6, -8, -8, -8};

        bus_a.start = 1'b0; bus_a.len_a = '0; bus_a.len_b = '0;
        bus_a.max_valid = 1'b0; bus_a.max = '0;
        bus_s.start = 1'b0; bus_s.len_a = '0; bus_s.len_b = '0;
        bus_s.max_valid = 1'b0; bus_s.max = '0;

        repeat (3) tick();
        check_idle("reset");
        rst = 1'b1;
        tick();

        // Abort during INIT
        bus_a.len_a = 5'd3; bus_a.len_b = 5'd4; bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        tick();
        check("init_busy", int'(bus_a.busy), 1);
        rst = 1'b0;
        #1;
        check_idle("rst_mid");
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_busy", int'(bus_a.busy), 0);

        // 2x2 alignment from the vector table
        wr0 = n_wr;
        do_start(2, 2, lat);
        check("first_nb_latency", lat, 5);
        for (int k = 0; k < 4; k++) begin
            run_cell(tbl[k].i, tbl[k].j, tbl[k].diag, tbl[k].left, tbl[k].up,
                     tbl[k].reply, tbl[k].bp, tbl[k].stray);
        end
        check("2x2_done", int'(bus_a.done), 1);
        check("2x2_busy_low", int'(bus_a.busy), 0);
        check("2x2_final", int'(bus_a.final_score), 2);
        tick();
        check("2x2_done_pulse", int'(bus_a.done), 0);
        check("2x2_final_held", int'(bus_a.final_score), 2);
        check("2x2_wr_count", n_wr - wr0, 4);

        // Illegal starts
        bus_a.len_a = 5'd0; bus_a.len_b = 5'd2; bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check("err_len_a0", int'(bus_a.err), 1);
        check("err_len_a0_busy", int'(bus_a.busy), 0);
        tick();
        check("err_pulse", int'(bus_a.err), 0);
        bus_a.len_a = 5'd2; bus_a.len_b = 5'(c_N + 1); bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check("err_len_b_big", int'(bus_a.err), 1);
        check("err_len_b_busy", int'(bus_a.busy), 0);

        // start while busy is ignored
        do_start(1, 1, lat);
        check("1x1_latency", lat, 4);
        bus_a.len_a = 5'd0; bus_a.len_b = 5'd0; bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
        check("busy_start_no_err", int'(bus_a.err), 0);
        check("busy_start_busy", int'(bus_a.busy), 1);
        run_cell(1, 1, 0, -2, -2, 5, 0, 1'b0);
        check("1x1_done", int'(bus_a.done), 1);
        check("1x1_final", int'(bus_a.final_score), 5);

        // Saturating row-0 initialisation on the narrow instance
        bus_s.len_a = 5'd1; bus_s.len_b = 5'd5; bus_s.start = 1'b1;
        tick();
        bus_s.start = 1'b0;
        lat = 1;
        while (!bus_s.nb_valid && lat < 100) begin tick(); lat++; end
        check("sat_latency", lat, 8);
        for (int j = 1; j <= 5; j++) begin
            n = 0;
            while (!bus_s.nb_valid && n < 100) begin tick(); n++; end
            check("sat_cell_j", int'(bus_s.cell_j), j);
            check("sat_up", int'(bus_s.up), exp_up[j]);
            check("sat_left", int'(bus_s.left), (j == 1) ? c_GAP_S : j - 1);
            check("sat_diag", int'(bus_s.diag), (j == 1) ? 0 : exp_up[j-1]);
            bus_s.max_valid = 1'b1;
            bus_s.max = c_SW_S'(j);
            tick();
            bus_s.max_valid = 1'b0;
        end
        check("sat_done", int'(bus_s.done), 1);
        check("sat_final", int'(bus_s.final_score), 5);

        // Full-size 8x8 against a reference matrix
        for (int k = 1; k <= 8; k++) begin
            sa[k] = (k * 3) % 4;
            sb[k] = (k * 5 + 1) % 4;
        end
        for (int k = 0; k <= 8; k++) begin
            h[0][k] = k * c_GAP;
            h[k][0] = k * c_GAP;
        end
        wr0 = n_wr;
        n = n_done;
        do_start(8, 8, lat);
        check("8x8_latency", lat, 11);
        for (int i = 1; i <= 8; i++) begin
            for (int j = 1; j <= 8; j++) begin
                ed  = h[i-1][j-1];
                el  = h[i][j-1];
                eu  = h[i-1][j];
                s   = (sa[i] == sb[j]) ? 2 : -1;
                rep = ed + s;
                if (el + c_GAP > rep) rep = el + c_GAP;
                if (eu + c_GAP > rep) rep = eu + c_GAP;
                h[i][j] = rep;
                run_cell(i, j, ed, el, eu, rep, int'($urandom_range(0, 2)),
                         (((i * 8 + j) % 5) == 0) && !(i == 8 && j == 8));
            end
        end
        check("8x8_done", int'(bus_a.done), 1);
        check("8x8_final", int'(bus_a.final_score), h[8][8]);
        tick();
        check("8x8_wr_count", n_wr - wr0, 64);
        check("8x8_done_once", n_done - n, 1);
        check("total_done", n_done, 3);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
